// File: rtl/resta4bits_div_seq_if.sv
// Handshake and data bundle between a requester and the sequential 4-bit divider.
interface resta4bits_div_seq_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       exact;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, exact
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, exact
  );
endinterface

// File: rtl/resta4bits_div_seq.sv
// Sequential unsigned 4-bit divider: repeated subtraction through one shared
// Resta4bits subtractor, one subtraction per clock, start/busy/done handshake.

// Combinational 4-bit ripple-borrow subtractor, D = A - B (mod 16).
module Resta4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] D
);
  logic [3:0] brw_s;

  assign brw_s[0] = 1'b0;

  genvar i;
  for (i = 0; i < 4; i++) begin : g_diff
    assign D[i] = A[i] ^ B[i] ^ brw_s[i];
  end
  for (i = 0; i < 3; i++) begin : g_brw
    assign brw_s[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw_s[i]);
  end
endmodule

module resta4bits_div_seq (
  input  logic                  clk,
  input  logic                  rst,
  resta4bits_div_seq_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [3:0] rem_r, rem_nxt_s;
  logic [3:0] bq_r, bq_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic [3:0] quot_r, quot_nxt_s;
  logic [3:0] remout_r, remout_nxt_s;
  logic       dbz_r, dbz_nxt_s;
  logic       exact_r, exact_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       done_r, done_nxt_s;
  logic [3:0] diff_s;
  logic       ge_s;

  // R >= Bq recovered from the wrapped difference: when MSBs differ the
  // operands decide directly, otherwise the difference sign does.
  function automatic logic no_borrow(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] d);
    logic brw;
    brw = (~a[3] & b[3]) | ((a[3] ~^ b[3]) & d[3]);
    return ~brw;
  endfunction

  Resta4bits u_sub (
    .A (rem_r),
    .B (bq_r),
    .D (diff_s)
  );

  assign ge_s = no_borrow(rem_r, bq_r, diff_s);

  // Next-state and datapath next values; everything holds unless updated.
  always_comb begin
    state_nxt_s  = state_r;
    rem_nxt_s    = rem_r;
    bq_nxt_s     = bq_r;
    cnt_nxt_s    = cnt_r;
    quot_nxt_s   = quot_r;
    remout_nxt_s = remout_r;
    dbz_nxt_s    = dbz_r;
    exact_nxt_s  = exact_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          rem_nxt_s   = bus.dividend;
          bq_nxt_s    = bus.divisor;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (bq_r == 4'd0) begin
          dbz_nxt_s    = 1'b1;
          quot_nxt_s   = 4'hF;
          remout_nxt_s = rem_r;
          exact_nxt_s  = 1'b0;
          state_nxt_s  = DONE;
        end else if (ge_s) begin
          rem_nxt_s   = diff_s;
          cnt_nxt_s   = cnt_r + 4'd1;
          state_nxt_s = CALC;
        end else begin
          quot_nxt_s   = cnt_r;
          remout_nxt_s = rem_r;
          exact_nxt_s  = (rem_r == 4'd0);
          dbz_nxt_s    = 1'b0;
          state_nxt_s  = DONE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rem_r    <= 4'd0;
      bq_r     <= 4'd0;
      cnt_r    <= 4'd0;
      quot_r   <= 4'd0;
      remout_r <= 4'd0;
      dbz_r    <= 1'b0;
      exact_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rem_r    <= rem_nxt_s;
      bq_r     <= bq_nxt_s;
      cnt_r    <= cnt_nxt_s;
      quot_r   <= quot_nxt_s;
      remout_r <= remout_nxt_s;
      dbz_r    <= dbz_nxt_s;
      exact_r  <= exact_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = remout_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.exact       = exact_r;
endmodule

// File: tb/tb_resta4bits_div_seq.sv
// Self-checking bench for resta4bits_div_seq: directed vector table plus
// randomized operations against an arithmetic reference model.
module tb_resta4bits_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  resta4bits_div_seq_if bus ();

  resta4bits_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int hold;
    int inject;
    int rst_at;
    int q;
    int r;
    int dbz;
    int ex;
    int lat;
    int dones;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One operation observed over a fixed 30-cycle window after the start edge.
  task automatic run_op(input int a, input int b, input int hold, input int inject,
                        input int rst_at, output int lat, output int dcnt,
                        output int bcnt, output int done_after, output int busy_after);
    lat = 0; dcnt = 0; bcnt = 0; done_after = 0; busy_after = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a[3:0];
    bus.divisor  = b[3:0];
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        if (lat == 0) lat = n;
      end
      if (bus.busy) bcnt++;
      if (lat != 0 && n == lat + 1) begin
        done_after = int'(bus.done);
        busy_after = int'(bus.busy);
      end
      bus.start = ((hold != 0) && (lat == 0 || n == lat)) || (n == inject);
      if (n == inject) begin
        bus.dividend = 4'd2;
        bus.divisor  = 4'd2;
      end
      rst = (n == rst_at);
    end
  endtask

  task automatic check_result(input string tag, input int q, input int r,
                              input int dbz, input int ex);
    check({tag, ".quotient"}, int'(bus.quotient), q);
    check({tag, ".remainder"}, int'(bus.remainder), r);
    check({tag, ".div_by_zero"}, int'(bus.div_by_zero), dbz);
    check({tag, ".exact"}, int'(bus.exact), ex);
  endtask

  initial begin
    int lat, dcnt, bcnt, dafter, bafter;
    int a, b, q, r, dbz, ex, elat;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor = 4'd0;

    //          a   b  hold inj rst   q   r  dbz ex lat dones
    vec[0]  = '{7,  2, 0,   0,  0,    3,  1, 0,  0, 5,  1};
    vec[1]  = '{15, 1, 0,   0,  0,    15, 0, 0,  1, 17, 1};
    vec[2]  = '{3,  9, 0,   0,  0,    0,  3, 0,  0, 2,  1};
    vec[3]  = '{0,  5, 0,   0,  0,    0,  0, 0,  1, 2,  1};
    vec[4]  = '{12, 5, 0,   0,  0,    2,  2, 0,  0, 4,  1};
    vec[5]  = '{8,  9, 0,   0,  0,    0,  8, 0,  0, 2,  1};
    vec[6]  = '{14, 7, 0,   0,  0,    2,  0, 0,  1, 4,  1};
    vec[7]  = '{9,  0, 0,   0,  0,    15, 9, 1,  0, 2,  1};
    vec[8]  = '{13, 3, 1,   0,  0,    4,  1, 0,  0, 6,  1};
    vec[9]  = '{15, 1, 0,   3,  0,    15, 0, 0,  1, 17, 1};
    vec[10] = '{15, 1, 0,   0,  5,    0,  0, 0,  0, 0,  0};
    vec[11] = '{6,  3, 0,   0,  0,    2,  0, 0,  1, 4,  1};

    repeat (2) @(negedge clk);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.done", int'(bus.done), 0);
    check_result("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d_%0d/%0d", i, vec[i].a, vec[i].b);
      run_op(vec[i].a, vec[i].b, vec[i].hold, vec[i].inject, vec[i].rst_at,
             lat, dcnt, bcnt, dafter, bafter);
      check({tag, ".dones"}, dcnt, vec[i].dones);
      if (vec[i].dones != 0) begin
        check({tag, ".latency"}, lat, vec[i].lat);
        check({tag, ".busy_cycles"}, bcnt, vec[i].lat);
        check({tag, ".done_after"}, dafter, 0);
        check({tag, ".busy_after"}, bafter, 0);
      end else begin
        check({tag, ".busy_end"}, int'(bus.busy), 0);
      end
      check_result(tag, vec[i].q, vec[i].r, vec[i].dbz, vec[i].ex);
    end

    for (int i = 0; i < 40; i++) begin
      string tag;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if (b == 0) begin
        q = 15; r = a; dbz = 1; ex = 0; elat = 2;
      end else begin
        q = a / b; r = a % b; dbz = 0; ex = (r == 0) ? 1 : 0; elat = q + 2;
      end
      tag = $sformatf("rand%0d_%0d/%0d", i, a, b);
      run_op(a, b, 0, 0, 0, lat, dcnt, bcnt, dafter, bafter);
      check({tag, ".dones"}, dcnt, 1);
      check({tag, ".latency"}, lat, elat);
      check_result(tag, q, r, dbz, ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/resta4bits_div_seq.md
# resta4bits_div_seq

Sequential unsigned 4-bit divider built on a single instance of the shared 4-bit subtractor `Resta4bits`. It computes quotient and remainder by repeated subtraction, with one subtractor use per clock. It sits above the combinational subtractor as its sequencer: it owns the operand registers, drives the subtractor inputs, decides from its result whether to continue, and reports completion with a start/busy/done handshake.

## Interface
Parameters:
- none (fixed 4-bit datapath, set by `Resta4bits`)

Ports (clock and reset first):
- clk  input  1  single system clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only in IDLE
- dividend  input  4  unsigned dividend, sampled with start
- divisor  input  4  unsigned divisor, sampled with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when the result is valid
- quotient  output  4  unsigned quotient, registered, held until next accepted start
- remainder  output  4  unsigned remainder, registered, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with the result
- exact  output  1  set with done when remainder is 0 and divisor is nonzero; held

## Operation
- Internal registers: R (running remainder, 4b), Bq (divisor, 4b), Q (count, 4b).
- `Resta4bits` instance: A=R, B=Bq, D=diff; only D is consumed.
- Unsigned no-borrow test (R >= Bq) is derived from D and the operand MSBs:
  - borrow = (~R[3] & Bq[3]) | (R[3] ~^ Bq[3]) & diff[3]
  - ge = ~borrow
- FSM states: IDLE, CALC, DONE.
  - IDLE: busy=0. If start=1: R<=dividend, Bq<=divisor, Q<=0, go to CALC. Otherwise hold.
  - CALC:
    - If Bq==0: div_by_zero<=1, quotient<=4'hF, remainder<=R, exact<=0, go to DONE.
    - Else if ge: R<=diff, Q<=Q+1, stay in CALC.
    - Else: quotient<=Q, remainder<=R, exact<=(R==0), div_by_zero<=0, go to DONE.
  - DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- start is ignored while busy=1. No queueing is performed.
- Q cannot wrap: the maximum quotient is 15 (15/1), so the 4-bit counter is sufficient.
- Output registers (quotient, remainder, div_by_zero, exact) update only on the CALC→DONE transition.

## Timing
- Reset values:
  - state=IDLE
  - busy=0, done=0
  - quotient=0, remainder=0, div_by_zero=0, exact=0
  - internal R, Bq, Q all 0
- Reset during CALC or DONE aborts the operation on that edge, with no done pulse. All outputs return to reset values.
- With start sampled at rising edge k, the final quotient is q:
  - CALC occupies cycles k+1 … k+1+q (q+1 cycles)
  - done is high during cycle k+q+2
  - the block is back in IDLE at cycle k+q+3
- Latency from start edge to done is q+2 cycles.
  - Minimum is 2 (divisor 0, or dividend < divisor).
  - Maximum is 17 (15/1).
- A new start is accepted at the first IDLE cycle, i.e. the cycle after done. A start asserted during the done cycle is ignored.
- busy rises the cycle after the start edge and falls the cycle after done.
- Results are valid from the done cycle onward and are stable until the next accepted start completes. They are not cleared by start.

## Test plan
- Reset then 7/2:
  - rst high 2 cycles: all outputs 0.
  - start with dividend=7, divisor=2: done in cycle k+5, quotient=3, remainder=1, exact=0, div_by_zero=0, busy high for 5 cycles.
- Boundary quotients:
  - 15/1: quotient=15, remainder=0, exact=1, done at k+17.
  - 3/9: quotient=0, remainder=3, done at k+2.
  - 0/5: quotient=0, remainder=0, exact=1, done at k+2.
- MSB-crossing cases for the borrow rule:
  - 12/5: quotient=2, remainder=2.
  - 8/9: quotient=0, remainder=8.
  - 14/7: quotient=2, remainder=0, exact=1.
- Divide by zero: 9/0 gives done at k+2, div_by_zero=1, quotient=4'hF, remainder=9, exact=0.
- Handshake abuse:
  - Hold start high continuously during 13/3: exactly one done (quotient=4, remainder=1). The next operation starts only from IDLE.
  - start asserted mid-CALC with different operands has no effect on the result.
- Reset mid-operation:
  - Start 15/1, assert rst at k+6: no done pulse, all outputs 0.
  - Then 6/3: quotient=2, remainder=0, exact=1, done at k'+4.
